// File: rtl/core_terminal_pkg.sv
// core_terminal_pkg: shared types and constants for the core-side HPS instruction link.
//   DEFAULT_DATA_W     default instruction/response width
//   DEFAULT_EMPTY_WORD word returned when the HPS reads an empty result FIFO
//   rd_state_e         HPS read-path FSM states
//   STATS_W, sat_inc   width and saturating increment for the optional statistics counters
package core_terminal_pkg;

    localparam int unsigned DEFAULT_DATA_W = 64;
    localparam logic [63:0] DEFAULT_EMPTY_WORD = 64'h0;
    localparam int unsigned STATS_W = 16;

    typedef enum logic [0:0] {
        R_IDLE,
        R_RESP
    } rd_state_e;

    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (v == '1) ? v : v + STATS_W'(1);
    endfunction

endpackage

// File: rtl/core_terminal_if.sv
// core_terminal_if: HPS-side and core-side signals of core_terminal.
//   HPS push : wr, wr_instruction, wr_busy
//   HPS pop  : rd, rd_valid, rd_instruction
//   Command  : cmd_valid, cmd_data, cmd_ready   (terminal -> core)
//   Response : rsp_valid, rsp_data, rsp_ready   (core -> terminal)
// Modport slave is the terminal's view; master is the view of the HPS terminal plus core.
interface core_terminal_if #(
    parameter int unsigned DATA_W = 64
);
    logic              wr;
    logic [DATA_W-1:0] wr_instruction;
    logic              wr_busy;
    logic              rd;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_instruction;
    logic              cmd_valid;
    logic [DATA_W-1:0] cmd_data;
    logic              cmd_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_ready;

    modport slave (
        input  wr, wr_instruction, rd, cmd_ready, rsp_valid, rsp_data,
        output wr_busy, rd_valid, rd_instruction, cmd_valid, cmd_data, rsp_ready
    );

    modport master (
        output wr, wr_instruction, rd, cmd_ready, rsp_valid, rsp_data,
        input  wr_busy, rd_valid, rd_instruction, cmd_valid, cmd_data, rsp_ready
    );
endinterface

// File: rtl/term_sync_fifo.sv
// term_sync_fifo: single-clock circular FIFO with registered flags and registered head word.
//   clk_i, rst_ni       clock, synchronous active-low reset
//   push_i, wdata_i     write strobe/data; ignored while full_o is high
//   pop_i               read strobe; ignored while empty_o is high
//   rdata_o             registered head word (valid while empty_o is low)
//   full_o, empty_o     registered flags, derived from the next-state count
module term_sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WIDTH-1:0]  head_q, head_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              push_ok, pop_ok;

    assign push_ok = push_i & ~full_q;
    assign pop_ok  = pop_i & ~empty_q;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_W'(1);
        end
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
        // The new head slot is only the one being written when the FIFO drains to empty
        // in this cycle; forward the write data since the RAM is not updated yet.
        if (push_ok && (rd_ptr_d == wr_ptr_q)) begin
            head_d = wdata_i;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign rdata_o = head_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;
endmodule

// File: rtl/core_terminal.sv
// core_terminal: core-side end of the HPS instruction link.
//   s_clk, s_reset_n   clock, synchronous active-low reset
//   bus (slave)        HPS push/pop and core command/response handshakes (see core_terminal_if)
// Commands pushed by the HPS are buffered and offered to the core over cmd_valid/cmd_ready;
// core responses are buffered and returned to the HPS one word per rd request.
// Optional macro CORE_TERMINAL_STATS_EN adds saturating counters cnt_cmd_accepted,
// cnt_cmd_dropped and cnt_rd_empty.
module core_terminal
    import core_terminal_pkg::*;
#(
    parameter int unsigned      CMD_DEPTH  = 16,
    parameter int unsigned      RSP_DEPTH  = 16,
    parameter int unsigned      DATA_W     = DEFAULT_DATA_W,
    parameter logic [DATA_W-1:0] EMPTY_WORD = DATA_W'(DEFAULT_EMPTY_WORD)
) (
    input  logic               s_clk,
    input  logic               s_reset_n,
`ifdef CORE_TERMINAL_STATS_EN
    output logic [STATS_W-1:0] cnt_cmd_accepted,
    output logic [STATS_W-1:0] cnt_cmd_dropped,
    output logic [STATS_W-1:0] cnt_rd_empty,
`endif
    core_terminal_if.slave     bus
);
    logic              cmd_full, cmd_empty;
    logic [DATA_W-1:0] cmd_head;
    logic              rsp_full, rsp_empty, rsp_pop;
    logic [DATA_W-1:0] rsp_head;
    rd_state_e         state_q, state_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    term_sync_fifo #(
        .DEPTH (CMD_DEPTH),
        .WIDTH (DATA_W)
    ) u_cmd_fifo (
        .clk_i   (s_clk),
        .rst_ni  (s_reset_n),
        .push_i  (bus.wr),
        .wdata_i (bus.wr_instruction),
        .pop_i   (bus.cmd_ready),
        .rdata_o (cmd_head),
        .full_o  (cmd_full),
        .empty_o (cmd_empty)
    );

    term_sync_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_W)
    ) u_rsp_fifo (
        .clk_i   (s_clk),
        .rst_ni  (s_reset_n),
        .push_i  (bus.rsp_valid),
        .wdata_i (bus.rsp_data),
        .pop_i   (rsp_pop),
        .rdata_o (rsp_head),
        .full_o  (rsp_full),
        .empty_o (rsp_empty)
    );

    assign bus.wr_busy   = cmd_full;
    assign bus.cmd_valid = ~cmd_empty;
    assign bus.cmd_data  = cmd_head;
    assign bus.rsp_ready = ~rsp_full;

    // HPS read path: the word is latched on the request and presented one cycle later.
    always_comb begin
        state_d   = state_q;
        rd_data_d = rd_data_q;
        rsp_pop   = 1'b0;
        unique case (state_q)
            R_IDLE: begin
                if (bus.rd) begin
                    state_d = R_RESP;
                    if (!rsp_empty) begin
                        rsp_pop   = 1'b1;
                        rd_data_d = rsp_head;
                    end else begin
                        rd_data_d = EMPTY_WORD;
                    end
                end
            end
            R_RESP: state_d = R_IDLE;
            default: state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge s_clk) begin
        if (!s_reset_n) begin
            state_q   <= R_IDLE;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.rd_valid       = (state_q == R_RESP);
    assign bus.rd_instruction = rd_data_q;

`ifdef CORE_TERMINAL_STATS_EN
    logic [STATS_W-1:0] acc_q, drop_q, rd_empty_q;

    always_ff @(posedge s_clk) begin
        if (!s_reset_n) begin
            acc_q      <= '0;
            drop_q     <= '0;
            rd_empty_q <= '0;
        end else begin
            if (bus.wr && !cmd_full) acc_q <= sat_inc(acc_q);
            if (bus.wr && cmd_full) drop_q <= sat_inc(drop_q);
            if ((state_q == R_IDLE) && bus.rd && rsp_empty) rd_empty_q <= sat_inc(rd_empty_q);
        end
    end

    assign cnt_cmd_accepted = acc_q;
    assign cnt_cmd_dropped  = drop_q;
    assign cnt_rd_empty     = rd_empty_q;
`endif
endmodule

// File: tb/tb_core_terminal.sv
// tb_core_terminal: scoreboard bench for core_terminal. Stimulus pushes expected words into
// queues; a negedge monitor pops and compares on every command transfer and every rd_valid.
module tb_core_terminal;
    logic s_clk = 1'b0;
    logic s_reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [63:0] cmd_q[$];
    logic [63:0] rd_q[$];

    always #5 s_clk = ~s_clk;

    core_terminal_if #(.DATA_W(64)) bus ();

`ifdef CORE_TERMINAL_STATS_EN
    logic [15:0] cnt_cmd_accepted, cnt_cmd_dropped, cnt_rd_empty;
`endif

    core_terminal dut (
        .s_clk            (s_clk),
        .s_reset_n        (s_reset_n),
`ifdef CORE_TERMINAL_STATS_EN
        .cnt_cmd_accepted (cnt_cmd_accepted),
        .cnt_cmd_dropped  (cnt_cmd_dropped),
        .cnt_rd_empty     (cnt_rd_empty),
`endif
        .bus              (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge s_clk);
        #1;
    endtask

    // Scoreboard monitor.
    always @(negedge s_clk) begin
        if (s_reset_n) begin
            if (bus.cmd_valid && bus.cmd_ready) begin
                if (cmd_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL cmd_unexpected: got %h, expected no transfer", bus.cmd_data);
                end else begin
                    check("cmd_data", bus.cmd_data, cmd_q.pop_front());
                end
            end
            if (bus.rd_valid) begin
                if (rd_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rd_unexpected: got %h, expected no rd_valid", bus.rd_instruction);
                end else begin
                    check("rd_instruction", bus.rd_instruction, rd_q.pop_front());
                end
            end
        end
    end

    task automatic drain_cmd(input string name);
        bus.cmd_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (cmd_q.size() == 0) break;
            tick();
        end
        check(name, 64'(cmd_q.size()), 64'd0);
        tick();
        tick();
        @(negedge s_clk);
        check({name, "_empty"}, 64'(bus.cmd_valid), 64'd0);
    endtask

    task automatic do_rd(input logic [63:0] exp);
        tick();
        bus.rd = 1'b1;
        rd_q.push_back(exp);
        tick();
        bus.rd = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr = 1'b0;
        bus.wr_instruction = '0;
        bus.rd = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_data = '0;

        // Reset state.
        tick();
        tick();
        s_reset_n = 1'b1;
        @(negedge s_clk);
        check("rst_wr_busy", 64'(bus.wr_busy), 64'd0);
        check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        check("rst_rd_instruction", bus.rd_instruction, 64'd0);
        check("rst_cmd_valid", 64'(bus.cmd_valid), 64'd0);
        check("rst_cmd_data", bus.cmd_data, 64'd0);
        check("rst_rsp_ready", 64'(bus.rsp_ready), 64'd1);

        // Three back-to-back pushes with the core always ready.
        bus.cmd_ready = 1'b1;
        tick();
        bus.wr = 1'b1;
        bus.wr_instruction = 64'h11;
        cmd_q.push_back(64'h11);
        @(negedge s_clk);
        check("a_cmd_valid_pre", 64'(bus.cmd_valid), 64'd0);
        tick();
        bus.wr_instruction = 64'h22;
        cmd_q.push_back(64'h22);
        @(negedge s_clk);
        check("a_cmd_valid_lat1", 64'(bus.cmd_valid), 64'd1);
        tick();
        bus.wr_instruction = 64'h33;
        cmd_q.push_back(64'h33);
        tick();
        bus.wr = 1'b0;
        drain_cmd("a_drain");

        // Fill with the core stalled, then a dropped push.
        tick();
        bus.cmd_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            bus.wr = 1'b1;
            bus.wr_instruction = 64'(i);
            cmd_q.push_back(64'(i));
            if (i == 15) begin
                @(negedge s_clk);
                check("b_busy_at_15", 64'(bus.wr_busy), 64'd0);
            end
        end
        tick();
        bus.wr_instruction = 64'hDEAD;
        @(negedge s_clk);
        check("b_busy_full", 64'(bus.wr_busy), 64'd1);
        tick();
        bus.wr = 1'b0;
        @(negedge s_clk);
        check("b_busy_hold", 64'(bus.wr_busy), 64'd1);
`ifdef CORE_TERMINAL_STATS_EN
        check("b_cnt_dropped", 64'(cnt_cmd_dropped), 64'd1);
        check("b_cnt_accepted", 64'(cnt_cmd_accepted), 64'd19);
`endif
        drain_cmd("b_drain");

        // Full FIFO with simultaneous push and dispatch: push refused, count drops to 15.
        tick();
        bus.cmd_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            bus.wr = 1'b1;
            bus.wr_instruction = 64'h100 + 64'(i);
            cmd_q.push_back(64'h100 + 64'(i));
        end
        tick();
        bus.wr_instruction = 64'hBEEF;
        bus.cmd_ready = 1'b1;
        @(negedge s_clk);
        check("e_busy_full", 64'(bus.wr_busy), 64'd1);
        tick();
        bus.wr = 1'b0;
        bus.cmd_ready = 1'b0;
        @(negedge s_clk);
        check("e_busy_fall", 64'(bus.wr_busy), 64'd0);
        check("e_left_15", 64'(cmd_q.size()), 64'd15);
`ifdef CORE_TERMINAL_STATS_EN
        check("e_cnt_dropped", 64'(cnt_cmd_dropped), 64'd2);
`endif
        drain_cmd("e_drain");
        tick();
        bus.cmd_ready = 1'b0;

        // Read of an empty result FIFO.
        tick();
        bus.rd = 1'b1;
        rd_q.push_back(64'h0);
        tick();
        bus.rd = 1'b0;
        @(negedge s_clk);
        check("c_rd_valid_lat", 64'(bus.rd_valid), 64'd1);
        tick();
        @(negedge s_clk);
        check("c_rd_valid_pulse", 64'(bus.rd_valid), 64'd0);
`ifdef CORE_TERMINAL_STATS_EN
        check("c_cnt_rd_empty", 64'(cnt_rd_empty), 64'd1);
`endif

        // One core response, then a read of it and a read of the now-empty FIFO.
        tick();
        bus.rsp_valid = 1'b1;
        bus.rsp_data = 64'hA5A5_0000_0000_0001;
        tick();
        bus.rsp_valid = 1'b0;
        bus.rd = 1'b1;
        rd_q.push_back(64'hA5A5_0000_0000_0001);
        tick();
        bus.rd = 1'b0;
        tick();
        do_rd(64'h0);
        tick();
`ifdef CORE_TERMINAL_STATS_EN
        @(negedge s_clk);
        check("d_cnt_rd_empty", 64'(cnt_rd_empty), 64'd2);
`endif

        // rd held through R_RESP must not start a second read.
        tick();
        bus.rsp_valid = 1'b1;
        bus.rsp_data = 64'hCAFE_0001;
        tick();
        bus.rsp_data = 64'hCAFE_0002;
        tick();
        bus.rsp_valid = 1'b0;
        bus.rd = 1'b1;
        rd_q.push_back(64'hCAFE_0001);
        tick();
        tick();
        bus.rd = 1'b0;
        tick();
        do_rd(64'hCAFE_0002);
        tick();

        // Fill the result FIFO; a 17th response is refused, then read all back.
        for (int i = 0; i < 16; i++) begin
            tick();
            bus.rsp_valid = 1'b1;
            bus.rsp_data = 64'h5000 + 64'(i);
        end
        tick();
        bus.rsp_data = 64'h5FFF;
        @(negedge s_clk);
        check("g_rsp_ready_full", 64'(bus.rsp_ready), 64'd0);
        tick();
        bus.rsp_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            do_rd(64'h5000 + 64'(i));
        end
        do_rd(64'h0);
        tick();
        @(negedge s_clk);
        check("g_rsp_ready_after", 64'(bus.rsp_ready), 64'd1);

        // Reset in the middle of dispatching five buffered commands.
        tick();
        bus.rsp_valid = 1'b1;
        bus.rsp_data = 64'h77;
        tick();
        bus.rsp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.wr = 1'b1;
            bus.wr_instruction = 64'h200 + 64'(i);
            cmd_q.push_back(64'h200 + 64'(i));
        end
        tick();
        bus.wr = 1'b0;
        bus.cmd_ready = 1'b1;
        tick();
        tick();
        s_reset_n = 1'b0;
        cmd_q.delete();
        tick();
        s_reset_n = 1'b1;
        bus.cmd_ready = 1'b0;
        @(negedge s_clk);
        check("f_cmd_valid", 64'(bus.cmd_valid), 64'd0);
        check("f_wr_busy", 64'(bus.wr_busy), 64'd0);
        check("f_rsp_ready", 64'(bus.rsp_ready), 64'd1);
        do_rd(64'h0);
        tick();
        tick();
`ifdef CORE_TERMINAL_STATS_EN
        @(negedge s_clk);
        check("f_cnt_rd_empty", 64'(cnt_rd_empty), 64'd1);
        check("f_cnt_accepted", 64'(cnt_cmd_accepted), 64'd0);
`endif

        tick();
        check("end_cmd_q", 64'(cmd_q.size()), 64'd0);
        check("end_rd_q", 64'(rd_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/core_terminal.md
Name: core_terminal

Overview:
- Core-side end of the HPS instruction link; the peer of the HPS terminal.
- Accepts 64-bit instructions pushed by the HPS terminal (wr / wr_instruction, backpressured by wr_busy) into a command FIFO, then dispatches them to the processing core over a valid/ready port.
- Collects 64-bit core responses into a result FIFO, which the HPS terminal drains with rd / rd_valid / rd_instruction.

Parameters:
- CMD_DEPTH, 16, command FIFO entries; power of 2, minimum 2.
- RSP_DEPTH, 16, result FIFO entries; power of 2, minimum 2.
- DATA_W, 64, instruction/response width.
- EMPTY_WORD, 64'h0, value returned on a read of an empty result FIFO.

Ports:
- s_clk  in  1  single clock.
- s_reset_n  in  1  reset; synchronous, active-low.
- wr  in  1  HPS push strobe, one word per cycle.
- wr_instruction  in  DATA_W  pushed instruction.
- wr_busy  out  1  command FIFO full; a push is refused while this is high.
- rd  in  1  HPS pop request strobe.
- rd_valid  out  1  one-cycle pulse marking rd_instruction valid.
- rd_instruction  out  DATA_W  popped response, or EMPTY_WORD.
- cmd_valid  out  1  instruction available to the core.
- cmd_data  out  DATA_W  head of the command FIFO.
- cmd_ready  in  1  core accepts cmd_data.
- rsp_valid  in  1  core offers a response.
- rsp_data  in  DATA_W  response word.
- rsp_ready  out  1  result FIFO not full.

Behaviour:
- Reset (s_reset_n low at a rising edge):
  - Both FIFOs emptied; pointers and counts set to 0.
  - wr_busy=0, rd_valid=0, rd_instruction=0, cmd_valid=0, cmd_data=0, rsp_ready=1.
  - Reset mid-transfer discards all buffered data without any handshake.
- FIFO form: each FIFO is a circular RAM with ADDR_W=$clog2(DEPTH) pointers that wrap modulo DEPTH, plus an (ADDR_W+1)-bit occupancy count.
- Full/empty flags: registered and derived from the next-state count.
- Command push:
  - Accepted when wr=1 and wr_busy=0.
  - wr while wr_busy=1 is dropped silently; FIFO contents are unchanged.
  - wr_busy reflects registered full. A push and a dispatch in the same cycle on a full FIFO still refuse the push; the count drops to DEPTH-1 and wr_busy falls the next cycle.
- Command dispatch:
  - cmd_valid = registered not-empty; cmd_data = registered head word.
  - Transfer occurs when cmd_valid=1 and cmd_ready=1.
  - cmd_data and cmd_valid stay stable until the transfer completes.
  - Latency from an accepted wr on an empty FIFO to cmd_valid=1 is 1 cycle; there is no combinational bypass.
  - Simultaneous push and dispatch: count unchanged, both pointers advance.
- Response capture:
  - Transfer occurs when rsp_valid=1 and rsp_ready=1.
  - rsp_ready = not-full (registered).
  - A simultaneous capture and HPS pop on a full FIFO is still refused.
- HPS read path, 2-state FSM:
  - R_IDLE: on rd=1, go to R_RESP. If the result FIFO is not empty, pop one word; otherwise return EMPTY_WORD.
  - R_RESP: drive rd_valid=1 for exactly one cycle with the word, then return to R_IDLE.
  - rd_instruction holds its last value while rd_valid=0.
  - rd asserted while in R_RESP is ignored. One read completes every 2 cycles at most.
  - A pop and a response capture in the same cycle on an empty FIFO returns EMPTY_WORD; the captured word is returned by the next read.
- Ordering: strict FIFO order in both directions; no reordering and no duplication.

Optional Feature:
- Macro: CORE_TERMINAL_STATS_EN.
- When defined, the following ports are added:
  - cnt_cmd_accepted  out  16  count of accepted pushes.
  - cnt_cmd_dropped  out  16  count of pushes refused while wr_busy=1.
  - cnt_rd_empty  out  16  count of reads answered with EMPTY_WORD.
  - Counters saturate at 16'hFFFF and clear on reset.
- When undefined: the ports, counters and their logic are absent; all other behaviour is identical.

Decomposition:
- Package core_terminal_pkg:
  - default DATA_W and EMPTY_WORD;
  - read FSM state enum {R_IDLE, R_RESP};
  - the stats counter width constant.
- Sub-module term_sync_fifo:
  - parameterised DEPTH/WIDTH, synchronous active-low reset;
  - push/pop inputs with registered full/empty flags and head-word output;
  - instantiated twice, once for commands and once for results.

Test Plan:
- Push 3 words (0x11, 0x22, 0x33) with cmd_ready=1 -> cmd_data shows 0x11, 0x22, 0x33 on consecutive cycles; cmd_valid first rises 1 cycle after the first wr.
- cmd_ready=0, 16 pushes of 0..15 -> wr_busy=1 after the 16th. A 17th push of 0xDEAD is dropped; with stats, cnt_cmd_dropped=1. Releasing cmd_ready yields exactly 0..15 in order.
- Empty result FIFO, rd pulse -> rd_valid 1 cycle later with rd_instruction=0; with stats, cnt_rd_empty=1.
- Core returns 0xA5A5_0000_0000_0001, then HPS issues rd -> rd_valid with that word; a second rd returns EMPTY_WORD.
- Full command FIFO with simultaneous wr and dispatch -> push refused; count becomes 15; wr_busy=0 next cycle.
- 5 words buffered, s_reset_n pulled low for 1 cycle mid-dispatch -> cmd_valid=0 and wr_busy=0 next cycle; a subsequent rd returns EMPTY_WORD.
